// File: rtl/rr_bus_arbiter16.sv
// Round-robin arbiter for 16 requesters sharing one word path.
// Grants one requester per burst, forwards valid/ready, rotates priority after each burst.
module rr_bus_arbiter16 #(
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      req,
    input  logic [15:0]      last,
    input  logic             out_ready,
    output logic [3:0]       sel,
    output logic [15:0]      grant,
    output logic             out_valid,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             done,
    output logic             abort
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [3:0]       ptr, ptr_n, sel_n, pick, idx;
    logic [15:0]      grant_n;
    logic [CNT_W-1:0] cnt_n;
    logic             done_n, abort_n, found;

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 15; k >= 0; k--) begin
            idx = ptr + 4'(k);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign out_valid = (state == BUSY) && req[sel];

    always_comb begin
        state_n = state;
        sel_n   = sel;
        grant_n = grant;
        cnt_n   = beat_cnt;
        ptr_n   = ptr;
        done_n  = 1'b0;
        abort_n = 1'b0;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (found) begin
                    sel_n   = pick;
                    grant_n = 16'b1 << pick;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (!req[sel]) begin
                    abort_n = 1'b1;
                    ptr_n   = sel + 4'd1;
                    cnt_n   = '0;
                    grant_n = '0;
                    state_n = IDLE;
                end else if (out_ready) begin
                    // Last flag and beat limit hitting together still yield one done.
                    if (last[sel] || beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                        done_n  = 1'b1;
                        ptr_n   = sel + 4'd1;
                        cnt_n   = '0;
                        grant_n = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = beat_cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            grant    <= '0;
            beat_cnt <= '0;
            done     <= 1'b0;
            abort    <= 1'b0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            grant    <= grant_n;
            beat_cnt <= cnt_n;
            done     <= done_n;
            abort    <= abort_n;
            ptr      <= ptr_n;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter16.sv
// Directed bench for rr_bus_arbiter16: inline checks plus a burst scoreboard
// fed by expected bursts and drained by a monitor on done/abort pulses.
module tb_rr_bus_arbiter16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic [15:0] last = '0;
    logic        out_ready = 1'b0;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        out_valid;
    logic [3:0]  beat_cnt;
    logic        done, abort;

    int vectors = 0;
    int miscompares = 0;
    int mon_beats = 0;

    typedef struct {
        logic [3:0] sel;
        int         beats;
        logic       ab;
    } exp_t;
    exp_t q[$];

    rr_bus_arbiter16 #(.MAX_BEATS(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .out_ready(out_ready),
        .sel(sel), .grant(grant), .out_valid(out_valid), .beat_cnt(beat_cnt),
        .done(done), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] s, input int b, input logic ab);
        exp_t e;
        e.sel = s; e.beats = b; e.ab = ab;
        q.push_back(e);
    endtask

    // Burst monitor: an end pulse closes the burst; accepted beats are counted as they happen.
    always @(negedge clk) begin
        if (rst) begin
            mon_beats = 0;
        end else begin
            if (done || abort) begin
                exp_t e;
                chk("done_abort_excl", 32'(done & abort), 32'd0);
                if (q.size() == 0) begin
                    chk("sb_unexpected_end", 32'(sel), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("sb_sel", 32'(sel), 32'(e.sel));
                    chk("sb_beats", 32'(mon_beats), 32'(e.beats));
                    chk("sb_kind_abort", 32'(abort), 32'(e.ab));
                end
                mon_beats = 0;
            end
            if (out_valid && out_ready) mon_beats++;
        end
    end

    logic [15:0] gseq [8] = '{16'h0001, 16'h0000, 16'h8000, 16'h0000,
                               16'h0001, 16'h0000, 16'h8000, 16'h0000};

    initial begin
        int n;
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pulses", 32'({done, abort}), 32'd0);
        rst = 1'b0;
        tick();

        // Single requester, last on third beat
        req = 16'h0010; out_ready = 1'b1; last = '0;
        push(4'd4, 3, 1'b0);
        tick();
        chk("t2_grant", 32'(grant), 32'h0010);
        chk("t2_sel", 32'(sel), 32'd4);
        tick();
        chk("t2_cnt1", 32'(beat_cnt), 32'd1);
        tick();
        chk("t2_cnt2", 32'(beat_cnt), 32'd2);
        last = 16'h0010;
        tick();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_idle_grant", 32'(grant), 32'd0);
        chk("t2_cnt0", 32'(beat_cnt), 32'd0);
        req = '0; last = '0;
        tick();
        chk("t2_done_pulse", 32'(done), 32'd0);

        // Reset in the middle of a burst (ptr is 5 here)
        req = 16'h0020;
        tick();
        chk("t1_grant", 32'(grant), 32'h0020);
        tick(); tick();
        chk("t1_cnt2", 32'(beat_cnt), 32'd2);
        rst = 1'b1; req = '0;
        #1;
        chk("t1_rst_grant", 32'(grant), 32'd0);
        chk("t1_rst_sel", 32'(sel), 32'd0);
        chk("t1_rst_cnt", 32'(beat_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t1_no_pulse", 32'({done, abort}), 32'd0);

        // Two requesters alternate, ptr restarts at 0
        req = 16'h8001; last = 16'hFFFF;
        push(4'd0, 1, 1'b0); push(4'd15, 1, 1'b0);
        push(4'd0, 1, 1'b0); push(4'd15, 1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t3_grant%0d", i), 32'(grant), 32'(gseq[i]));
        end
        req = '0; last = '0;
        tick();

        // Backpressure freezes the burst
        req = 16'h0004; out_ready = 1'b0;
        tick();
        chk("t4_sel", 32'(sel), 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_cnt_frozen", 32'(beat_cnt), 32'd0);
            chk("t4_grant_stable", 32'(grant), 32'h0004);
            chk("t4_valid", 32'(out_valid), 32'd1);
        end

        // Beat limit, with a foreign last that must be ignored, then handover to 3
        req = 16'h000C; last = 16'h0008; out_ready = 1'b1;
        push(4'd2, 8, 1'b0); push(4'd3, 1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) begin
                chk("t5_cnt", 32'(beat_cnt), 32'(i));
                chk("t5_grant", 32'(grant), 32'h0004);
            end
        end
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_idle", 32'(grant), 32'd0);
        chk("t5_cnt0", 32'(beat_cnt), 32'd0);
        tick();
        chk("t5_next_sel", 32'(sel), 32'd3);
        chk("t5_next_grant", 32'(grant), 32'h0008);
        tick();
        chk("t5_done2", 32'(done), 32'd1);
        req = '0; last = '0;
        tick();

        // Requester drops mid-burst; next search starts at 8
        req = 16'h0080;
        push(4'd7, 1, 1'b1); push(4'd9, 1, 1'b0);
        tick();
        chk("t6_grant", 32'(grant), 32'h0080);
        tick();
        chk("t6_cnt1", 32'(beat_cnt), 32'd1);
        req = 16'h0240; last = 16'h0200;
        tick();
        chk("t6_abort", 32'(abort), 32'd1);
        chk("t6_no_done", 32'(done), 32'd0);
        chk("t6_cnt0", 32'(beat_cnt), 32'd0);
        chk("t6_idle", 32'(grant), 32'd0);
        tick();
        chk("t6_sel9", 32'(sel), 32'd9);
        chk("t6_grant9", 32'(grant), 32'h0200);
        tick();
        chk("t6_done9", 32'(done), 32'd1);
        req = '0; last = '0;

        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick(); tick();
        chk("sb_drain", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
